// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial add sequencer. It holds the FSM state
// encoding, the default operand width, and the helper that sizes the bit
// counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter only has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_add_cell.sv
// full_add_cell
// One-bit full adder built from two half-adder stages. The carry-out is the OR
// of the two stage carries.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p1;
    logic g1;
    logic g2;

    assign p1 = a ^ b;
    assign g1 = a & b;
    assign s  = p1 ^ ci;
    assign g2 = p1 & ci;
    assign co = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial add sequencer. It captures two WIDTH-bit operands on an accepted
// start. It then feeds one full_add_cell LSB-first for WIDTH enabled cycles,
// keeping the carry in a register. The sum and carry_out registers are loaded
// on the RUN->DONE transition and hold their values until the next completion.
// Optional feature macro: SERIAL_ADD_SUB_EN. It adds the sub port and
// two's-complement subtraction. With subtraction, carry_out=1 means A >= B.
// Parameters:
//   WIDTH      operand/sum width, 2..16
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes all state
//   start      request, sampled in IDLE only
//   op_a/op_b  operands, captured on an accepted start
//   sub        subtract select (SERIAL_ADD_SUB_EN only)
//   busy       high in RUN
//   done       high in DONE
//   sum        result register
//   carry_out  final carry / not-borrow
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per enabled cycle
// DONE  | result valid, done asserted
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               b_bit;
    logic               carry_init;
    logic               bit_s;
    logic               bit_co;
    logic               last_bit;

`ifdef SERIAL_ADD_SUB_EN
    logic               sub_q;

    // Subtraction is A + ~B + 1. The +1 comes in through the initial carry.
    assign b_bit      = b_sr[0] ^ sub_q;
    assign carry_init = sub;
`else
    assign b_bit      = b_sr[0];
    assign carry_init = 1'b0;
`endif

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    full_add_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_bit),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ena) begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (last_bit) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= op_a;
                        b_sr   <= op_b;
                        res_sr <= '0;
                        cnt    <= '0;
                        carry  <= carry_init;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q  <= sub;
`endif
                    end
                end
                RUN: begin
                    carry  <= bit_co;
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum       <= {bit_s, res_sr[WIDTH-1:1]};
                        carry_out <= bit_co;
                    end
                end
                default: ;
            endcase
        end
    end

    // These outputs decode the state register, so they carry no path from the inputs.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       sub_i = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    int n_checks = 0;
    int n_pass   = 0;

    int         first_done, n_done, n_busy;
    logic [7:0] dsum;
    logic       dco;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_i),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Cycle 0 presents the start. Cycles 1..ncyc are each sampled at the falling edge.
    // The bench can drop ena, pulse an extra start, or pull reset in chosen cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int ena_lo_first, input int ena_lo_last,
                          input int extra_start, input int rst_cyc, input int ncyc,
                          output int fd, output int nd, output int nb,
                          output logic [7:0] rs, output logic rc);
        fd = 0; nd = 0; nb = 0; rs = '0; rc = 1'b0;
        @(posedge clk); #1;
        op_a = a; op_b = b; sub_i = s; start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            start = (n == extra_start);
            ena   = !(n >= ena_lo_first && n <= ena_lo_last);
            rst_n = (n != rst_cyc);
            op_a  = 8'hC3; op_b = 8'h3C;
            @(negedge clk);
            if (n == rst_cyc) begin
                check("midrun_rst_busy", 16'(busy), 16'd0);
                check("midrun_rst_done", 16'(done), 16'd0);
                check("midrun_rst_sum", 16'(sum), 16'd0);
                check("midrun_rst_co", 16'(carry_out), 16'd0);
            end
            if (done) begin
                if (fd == 0) begin
                    fd = n; rs = sum; rc = carry_out;
                end
                nd++;
            end
            if (busy) nb++;
        end
        start = 1'b0; ena = 1'b1; rst_n = 1'b1;
    endtask

    initial begin
        #2;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_sum", 16'(sum), 16'd0);
        check("rst_co", 16'(carry_out), 16'd0);
        @(negedge clk); rst_n = 1'b1;

        // 0x5A + 0x33 = 0x8D: busy in cycles 1..8, done only in cycle 9
        run_op(8'h5A, 8'h33, 1'b0, 0, 0, 0, 0, 14, first_done, n_done, n_busy, dsum, dco);
        check("add_done_cycle", 16'(first_done), 16'd9);
        check("add_done_count", 16'(n_done), 16'd1);
        check("add_busy_count", 16'(n_busy), 16'd8);
        check("add_sum", 16'(dsum), 16'h8D);
        check("add_co", 16'(dco), 16'd0);
        check("add_sum_hold", 16'(sum), 16'h8D);

        // Asynchronous reset in the middle of a cycle, with busy inputs
        @(posedge clk); #3;
        op_a = 8'hA7; op_b = 8'h6E; start = 1'b1; ena = 1'b1;
        rst_n = 1'b0; #1;
        check("async_rst_sum", 16'(sum), 16'd0);
        check("async_rst_co", 16'(carry_out), 16'd0);
        check("async_rst_busy", 16'(busy), 16'd0);
        @(negedge clk); start = 1'b0; rst_n = 1'b1;

        // 0xFF + 0x01 wraps; the next start comes in cycle 10, back to back
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, 0, 0, 9, first_done, n_done, n_busy, dsum, dco);
        check("ovf_done_cycle", 16'(first_done), 16'd9);
        check("ovf_sum", 16'(dsum), 16'h00);
        check("ovf_co", 16'(dco), 16'd1);
        run_op(8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 10, first_done, n_done, n_busy, dsum, dco);
        check("b2b_done_cycle", 16'(first_done), 16'd9);
        check("b2b_sum", 16'(dsum), 16'h00);
        check("b2b_co", 16'(dco), 16'd0);

        // ena is low in cycles 3..5 and start is pulsed in cycle 2 while busy; done moves to cycle 12
        run_op(8'h5A, 8'h33, 1'b0, 3, 5, 2, 0, 24, first_done, n_done, n_busy, dsum, dco);
        check("ena_done_cycle", 16'(first_done), 16'd12);
        check("ena_done_count", 16'(n_done), 16'd1);
        check("ena_busy_count", 16'(n_busy), 16'd11);
        check("ena_sum", 16'(dsum), 16'h8D);

        // Reset in cycle 4 of 0xFF + 0x01, which discards the operation
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, 0, 4, 14, first_done, n_done, n_busy, dsum, dco);
        check("midrun_no_done", 16'(n_done), 16'd0);
        check("midrun_sum_after", 16'(sum), 16'd0);
        run_op(8'h12, 8'h34, 1'b0, 0, 0, 0, 0, 10, first_done, n_done, n_busy, dsum, dco);
        check("fresh_done_cycle", 16'(first_done), 16'd9);
        check("fresh_sum", 16'(dsum), 16'h46);
        check("fresh_co", 16'(dco), 16'd0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h20, 8'h10, 1'b1, 0, 0, 0, 0, 10, first_done, n_done, n_busy, dsum, dco);
        check("sub_pos_sum", 16'(dsum), 16'h10);
        check("sub_pos_co", 16'(dco), 16'd1);
        run_op(8'h10, 8'h20, 1'b1, 0, 0, 0, 0, 10, first_done, n_done, n_busy, dsum, dco);
        check("sub_neg_sum", 16'(dsum), 16'hF0);
        check("sub_neg_co", 16'(dco), 16'd0);
        run_op(8'h5A, 8'h33, 1'b0, 0, 0, 0, 0, 10, first_done, n_done, n_busy, dsum, dco);
        check("sub_off_sum", 16'(dsum), 16'h8D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
